// File: rtl/fir_out_conditioner.sv
// FIR output conditioner: decimate the accumulator stream, rescale each kept
// sample with a round-half-up arithmetic shift, saturate to the output width
// and buffer the result in a small first-word-fall-through FIFO.
module fir_out_conditioner #(
    parameter int IN_WIDTH   = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int FRAC_SHIFT = 4,
    parameter int DECIM      = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [IN_WIDTH-1:0]               in_data,
    input  logic                              out_ready,
    input  logic                              clr_ovf,
    output logic                              out_valid,
    output logic [OUT_WIDTH-1:0]              out_data,
    output logic                              overflow,
    output logic                              drop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fill
);

    // Phase counter needs at least one bit even when DECIM is 1.
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(DECIM - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(FIFO_DEPTH);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    // Saturation bounds expressed in the one-bit-wider working precision.
    localparam logic signed [IN_WIDTH:0] SAT_MAX =
        (IN_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
    localparam logic signed [IN_WIDTH:0] SAT_MIN = ~SAT_MAX;

    // ------------------------------------------------------------------
    // Decimation
    // ------------------------------------------------------------------
    logic [PH_W-1:0] phase;
    logic            keep;

    assign keep = in_valid && (phase == '0);

    // Phase advances only on valid input samples and wraps at DECIM-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
        end else if (in_valid) begin
            if (phase == PH_LAST) begin
                phase <= '0;
            end else begin
                phase <= phase + PH_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Rounding shift
    // ------------------------------------------------------------------
    logic signed [IN_WIDTH:0] ext;
    logic signed [IN_WIDTH:0] r;

    assign ext = {in_data[IN_WIDTH-1], in_data};

    generate
        if (FRAC_SHIFT == 0) begin : g_no_round
            assign r = ext;
        end else begin : g_round
            // Adding half an LSB before the floor shift gives round-half-up.
            localparam logic signed [IN_WIDTH:0] RND_HALF =
                (IN_WIDTH+1)'(1) << (FRAC_SHIFT - 1);
            assign r = (ext + RND_HALF) >>> FRAC_SHIFT;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Saturation
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] sat_val;
    logic                 sat_hit;

    // Clamp the rescaled value to the signed output range.
    always_comb begin
        sat_val = r[OUT_WIDTH-1:0];
        sat_hit = 1'b0;
        if (r > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end else if (r < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_WIDTH-1:0];
            sat_hit = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stage S1 and sticky overflow
    // ------------------------------------------------------------------
    logic                 s1_valid;
    logic [OUT_WIDTH-1:0] s1_data;

    // Register the conditioned sample; s1_valid is a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) begin
                s1_data <= sat_val;
            end
        end
    end

    // Overflow is sticky; a new saturation beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (keep && sat_hit) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     rd_next;
    logic                 full;
    logic                 empty;
    logic                 pop;
    logic                 push_ok;

    assign full      = (fill == FILL_FULL);
    assign empty     = (fill == '0);
    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    // A pop frees the slot in the same edge, so a full FIFO can still accept.
    assign push_ok   = s1_valid & (~full | pop);
    assign drop      = s1_valid & full & ~pop;
    assign rd_next   = rd_ptr + PTR_W'(1);

    // Storage array; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= s1_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push_ok, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Registered head: next entry after a pop, the incoming sample when the
    // FIFO is (or becomes) empty, otherwise hold so data stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (pop && (fill > FILL_ONE)) begin
            out_data <= mem[rd_next];
        end else if (push_ok && (empty || (pop && (fill == FILL_ONE)))) begin
            out_data <= s1_data;
        end
    end

endmodule

// File: tb/tb_fir_out_conditioner.sv
// Bench for fir_out_conditioner: one instance with DECIM=2 (suffix _a) and one
// with DECIM=1 (suffix _b). Expected outputs are queued when stimulus is
// driven and compared when the consumer pops them.
module tb_fir_out_conditioner;

    logic clk;
    logic rst;

    logic               in_valid_a, out_ready_a, clr_ovf_a;
    logic signed [31:0] in_data_a;
    logic               out_valid_a, overflow_a, drop_a;
    logic signed [15:0] out_data_a;
    logic [2:0]         fill_a;

    logic               in_valid_b, out_ready_b, clr_ovf_b;
    logic signed [31:0] in_data_b;
    logic               out_valid_b, overflow_b, drop_b;
    logic signed [15:0] out_data_b;
    logic [2:0]         fill_b;

    int q_a[$];
    int q_b[$];
    bit ph_a;
    int n_chk;
    int n_pass;

    fir_out_conditioner #(
        .IN_WIDTH(32), .OUT_WIDTH(16), .FRAC_SHIFT(4), .DECIM(2), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_data(in_data_a),
        .out_ready(out_ready_a), .clr_ovf(clr_ovf_a),
        .out_valid(out_valid_a), .out_data(out_data_a),
        .overflow(overflow_a), .drop(drop_a), .fill(fill_a)
    );

    fir_out_conditioner #(
        .IN_WIDTH(32), .OUT_WIDTH(16), .FRAC_SHIFT(4), .DECIM(1), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_data(in_data_b),
        .out_ready(out_ready_b), .clr_ovf(clr_ovf_b),
        .out_valid(out_valid_b), .out_data(out_data_b),
        .overflow(overflow_b), .drop(drop_b), .fill(fill_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: round half up at 4 fractional bits, clamp to 16-bit signed.
    function automatic int scale(input int x);
        longint v;
        v = (longint'(x) + 64'sd8) >>> 4;
        if (v > 64'sd32767) return 32767;
        if (v < -64'sd32768) return -32768;
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int d);
        in_valid_a = 1'b1;
        in_data_a  = d;
        if (ph_a == 1'b0) q_a.push_back(scale(d));
        ph_a = ~ph_a;
        tick();
        in_valid_a = 1'b0;
    endtask

    task automatic drive_b(input int d, input bit exp_push);
        in_valid_b = 1'b1;
        in_data_b  = d;
        if (exp_push) q_b.push_back(scale(d));
        tick();
        in_valid_b = 1'b0;
    endtask

    task automatic drain_a();
        for (int i = 0; i < 40; i++) begin
            if (q_a.size() == 0 && fill_a == 3'd0) break;
            tick();
        end
        check("drain_a_queue", q_a.size(), 0);
        check("drain_a_fill", fill_a, 0);
    endtask

    task automatic drain_b();
        for (int i = 0; i < 40; i++) begin
            if (q_b.size() == 0 && fill_b == 3'd0) break;
            tick();
        end
        check("drain_b_queue", q_b.size(), 0);
        check("drain_b_fill", fill_b, 0);
    endtask

    // Consumer side: every accepted word must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid_a && out_ready_a) begin
                if (q_a.size() == 0) check("a_unexpected_out", out_data_a, 32'sh7fffffff);
                else check("a_out_data", out_data_a, q_a.pop_front());
            end
            if (out_valid_b && out_ready_b) begin
                if (q_b.size() == 0) check("b_unexpected_out", out_data_b, 32'sh7fffffff);
                else check("b_out_data", out_data_b, q_b.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[8];
        n_chk = 0;
        n_pass = 0;
        ph_a = 1'b0;
        rst = 1'b1;
        in_valid_a = 0; in_data_a = 0; out_ready_a = 0; clr_ovf_a = 0;
        in_valid_b = 0; in_data_b = 0; out_ready_b = 0; clr_ovf_b = 0;
        repeat (2) tick();

        check("rst_a_valid", out_valid_a, 0);
        check("rst_a_fill", fill_a, 0);
        check("rst_a_data", out_data_a, 0);
        check("rst_a_ovf", overflow_a, 0);
        check("rst_a_drop", drop_a, 0);
        check("rst_b_valid", out_valid_b, 0);
        check("rst_b_fill", fill_b, 0);
        check("rst_b_data", out_data_b, 0);
        check("rst_b_ovf", overflow_b, 0);
        check("rst_b_drop", drop_b, 0);
        rst = 1'b0;
        tick();

        // Decimation by 2 with rounding and first-output latency.
        out_ready_a = 1'b1;
        drive_a(16);
        check("lat_edge_n_valid", out_valid_a, 0);
        drive_a(32);
        check("lat_edge_n1_valid", out_valid_a, 1);
        check("lat_edge_n1_data", out_data_a, 1);
        drive_a(48);
        drive_a(64);
        drain_a();

        // Rounding edges and full-rate throughput without drops.
        out_ready_b = 1'b1;
        vals = '{24, 23, -24, -25, 100, 200, -300, 400};
        foreach (vals[i]) begin
            drive_b(vals[i], 1'b1);
            check("thru_no_drop", drop_b, 0);
        end
        drain_b();
        check("round_ovf_clear", overflow_b, 0);

        // Saturation and sticky overflow priority.
        drive_b(1048576, 1'b1);
        check("sat_pos_ovf", overflow_b, 1);
        drive_b(-1048576, 1'b1);
        check("sat_neg_ovf", overflow_b, 1);
        clr_ovf_b = 1'b1;
        drive_b(1048576, 1'b1);
        clr_ovf_b = 1'b0;
        check("sat_set_wins", overflow_b, 1);
        clr_ovf_b = 1'b1;
        tick();
        clr_ovf_b = 1'b0;
        check("ovf_cleared", overflow_b, 0);
        drain_b();

        // Backpressure: fill to 4, drop samples 5 and 6.
        out_ready_b = 1'b0;
        for (int k = 1; k <= 4; k++) drive_b(k << 4, 1'b1);
        check("bp_no_drop_4", drop_b, 0);
        drive_b(5 << 4, 1'b0);
        check("bp_drop_5", drop_b, 1);
        check("bp_stall_data_5", out_data_b, 1);
        drive_b(6 << 4, 1'b0);
        check("bp_drop_6", drop_b, 1);
        tick();
        check("bp_drop_idle", drop_b, 0);
        check("bp_fill_full", fill_b, 4);
        check("bp_stall_valid", out_valid_b, 1);
        check("bp_stall_data", out_data_b, 1);
        out_ready_b = 1'b1;
        drain_b();

        // Full FIFO with push and pop on the same edge.
        out_ready_b = 1'b0;
        for (int k = 10; k <= 14; k++) drive_b(k << 4, 1'b1);
        check("fp_fill_before", fill_b, 4);
        out_ready_b = 1'b1;
        #1;
        check("fp_no_drop", drop_b, 0);
        tick();
        check("fp_fill_after", fill_b, 4);
        check("fp_head_after", out_data_b, 11);
        drain_b();
        out_ready_b = 1'b0;

        // Asynchronous reset mid-operation, then phase restart.
        out_ready_a = 1'b0;
        for (int k = 1; k <= 7; k++) drive_a(k << 4);
        check("mid_fill_before_rst", fill_a, 3);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid_a, 0);
        check("mid_rst_fill", fill_a, 0);
        check("mid_rst_data", out_data_a, 0);
        q_a.delete();
        q_b.delete();
        ph_a = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        out_ready_a = 1'b1;
        repeat (2) tick();
        check("post_rst_fill", fill_a, 0);
        check("post_rst_valid", out_valid_a, 0);
        drive_a(32);
        drive_a(48);
        drain_a();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
